// File: rtl/res_collector_pkg.sv
// -----------------------------------------------------------------------------
// res_collector_pkg
//   Shared types and constants for the result collector.
//   - state_t    : collector FSM state (2-bit)
//   - CHECKSUM_W : width of the running checksum output
//   - count_w()  : width needed to hold an item count in 0..num
// -----------------------------------------------------------------------------
package res_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int CHECKSUM_W = 16;

    // Count must represent NUM itself (the "full" value), hence num+1.
    function automatic int count_w(input int num);
        return $clog2(num + 1);
    endfunction

endpackage

// File: rtl/res_buffer.sv
// -----------------------------------------------------------------------------
// res_buffer
//   NUM x ITEM_WIDTH register array with a single write port and a flat
//   packed read port exposing every slot at once.
// Ports
//   clk_i      : clock, writes on posedge
//   reset_ni   : asynchronous active-low reset, clears every slot
//   wr_en_i    : write strobe
//   wr_idx_i   : slot to write (must be < NUM when wr_en_i is high)
//   wr_data_i  : item to store
//   payload_o  : slot k at [k*ITEM_WIDTH +: ITEM_WIDTH]
// -----------------------------------------------------------------------------
module res_buffer
    import res_collector_pkg::*;
#(
    parameter int NUM        = 100,
    parameter int ITEM_WIDTH = 8,
    parameter int IDX_W      = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      wr_en_i,
    input  logic [IDX_W-1:0]          wr_idx_i,
    input  logic [ITEM_WIDTH-1:0]     wr_data_i,
    output logic [NUM*ITEM_WIDTH-1:0] payload_o
);

    // Plain registers rather than block RAM: the whole buffer is read in
    // parallel through payload_o and must clear on reset.
    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_slot
            logic [ITEM_WIDTH-1:0] slot_reg;

            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    slot_reg <= '0;
                end else if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
                    slot_reg <= wr_data_i;
                end
            end

            assign payload_o[gi*ITEM_WIDTH +: ITEM_WIDTH] = slot_reg;
        end
    endgenerate

endmodule

// File: rtl/res_collector.sv
// -----------------------------------------------------------------------------
// res_collector
//   Captures the bfm result stream into a packed payload buffer. Collects NUM
//   items, then raises done_o so the whole buffer can be read in one transfer.
// Ports
//   clk_i      : clock, all state updates on posedge
//   reset_ni   : asynchronous active-low reset
//   start_i    : one-cycle pulse, begin or restart a run
//   valid_i    : res_i carries a result this cycle
//   res_i      : result item
//   ready_o    : collector accepts an item this cycle (registered, state only)
//   payload_o  : packed buffer, item k at [k*ITEM_WIDTH +: ITEM_WIDTH]
//   count_o    : items accepted in the current run (0..NUM)
//   done_o     : run complete, payload stable
//   overflow_o : sticky, valid_i seen while in DONE
//   checksum_o : 16-bit wrapping sum of accepted items
// Configuration
//   RES_COLLECTOR_CHECKSUM_EN : when defined, checksum_o is the running sum;
//                               otherwise checksum_o is tied to 0.
// -----------------------------------------------------------------------------
module res_collector
    import res_collector_pkg::*;
#(
    parameter int NUM        = 100,
    parameter int ITEM_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      start_i,
    input  logic                      valid_i,
    input  logic [ITEM_WIDTH-1:0]     res_i,
    output logic                      ready_o,
    output logic [NUM*ITEM_WIDTH-1:0] payload_o,
    output logic [count_w(NUM)-1:0]   count_o,
    output logic                      done_o,
    output logic                      overflow_o,
    output logic [CHECKSUM_W-1:0]     checksum_o
);

    localparam int CW = count_w(NUM);
    localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

    state_t        state_reg;
    logic          ready_reg;
    logic          done_reg;
    logic          overflow_reg;
    logic [CW-1:0] count_reg;
    logic          wr_en;

    // A beat is stored only in COLLECT and only if no restart is requested in
    // the same cycle. In COLLECT count_reg < NUM, so the slot is in range.
    assign wr_en = (state_reg == COLLECT) && valid_i && !start_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg    <= IDLE;
            ready_reg    <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            count_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_reg <= COLLECT;
                        ready_reg <= 1'b1;
                        count_reg <= '0;
                    end
                end
                COLLECT: begin
                    if (start_i) begin
                        count_reg <= '0;
                    end else if (valid_i) begin
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == CW'(NUM - 1)) begin
                            state_reg <= DONE;
                            ready_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start_i) begin
                        state_reg    <= COLLECT;
                        ready_reg    <= 1'b1;
                        done_reg     <= 1'b0;
                        overflow_reg <= 1'b0;
                        count_reg    <= '0;
                    end else if (valid_i) begin
                        overflow_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RES_COLLECTOR_CHECKSUM_EN
    logic [CHECKSUM_W-1:0] checksum_reg;

    // Every start clears the sum regardless of state; accepts add to it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            checksum_reg <= '0;
        end else if (start_i) begin
            checksum_reg <= '0;
        end else if (wr_en) begin
            checksum_reg <= checksum_reg + CHECKSUM_W'(res_i);
        end
    end

    assign checksum_o = checksum_reg;
`else
    assign checksum_o = '0;
`endif

    res_buffer #(
        .NUM        (NUM),
        .ITEM_WIDTH (ITEM_WIDTH),
        .IDX_W      (IW)
    ) u_buffer (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .wr_en_i   (wr_en),
        .wr_idx_i  (count_reg[IW-1:0]),
        .wr_data_i (res_i),
        .payload_o (payload_o)
    );

    assign ready_o    = ready_reg;
    assign done_o     = done_reg;
    assign overflow_o = overflow_reg;
    assign count_o    = count_reg;

endmodule

// File: tb/tb_res_collector.sv
// -----------------------------------------------------------------------------
// tb_res_collector
//   Directed scenarios followed by random traffic, all compared against a
//   behavioural model of the collector kept in the bench.
// -----------------------------------------------------------------------------
module tb_res_collector;

    localparam int NUM = 4;
    localparam int IW  = 8;
    localparam int CW  = $clog2(NUM + 1);

    logic                clk_i;
    logic                reset_ni;
    logic                start_i;
    logic                valid_i;
    logic [IW-1:0]       res_i;
    logic                ready_o;
    logic [NUM*IW-1:0]   payload_o;
    logic [CW-1:0]       count_o;
    logic                done_o;
    logic                overflow_o;
    logic [15:0]         checksum_o;

    res_collector #(.NUM(NUM), .ITEM_WIDTH(IW)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .start_i    (start_i),
        .valid_i    (valid_i),
        .res_i      (res_i),
        .ready_o    (ready_o),
        .payload_o  (payload_o),
        .count_o    (count_o),
        .done_o     (done_o),
        .overflow_o (overflow_o),
        .checksum_o (checksum_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks;
    int failures;

    // Reference model: a run is either in progress, finished, or not started.
    bit            m_running;
    bit            m_done;
    bit            m_ovf;
    int            m_count;
    int            m_sum;
    logic [IW-1:0] m_items [NUM];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [NUM*IW-1:0] m_payload();
        logic [NUM*IW-1:0] p;
        for (int k = 0; k < NUM; k++) p[k*IW +: IW] = m_items[k];
        return p;
    endfunction

    function automatic logic [15:0] m_checksum();
`ifdef RES_COLLECTOR_CHECKSUM_EN
        return 16'(m_sum);
`else
        return 16'h0;
`endif
    endfunction

    task automatic model_reset();
        m_running = 0; m_done = 0; m_ovf = 0; m_count = 0; m_sum = 0;
        for (int k = 0; k < NUM; k++) m_items[k] = '0;
    endtask

    task automatic model_edge(input bit s, input bit v, input logic [IW-1:0] d);
        if (s) begin
            m_running = 1; m_done = 0; m_ovf = 0; m_count = 0; m_sum = 0;
        end else if (m_running && v) begin
            m_items[m_count] = d;
            m_count++;
            m_sum = (m_sum + int'(d)) % 65536;
            if (m_count == NUM) begin
                m_running = 0;
                m_done    = 1;
            end
        end else if (m_done && v) begin
            m_ovf = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ready"},    64'(ready_o),    64'(m_running));
        check({tag, ".count"},    64'(count_o),    64'(m_count));
        check({tag, ".done"},     64'(done_o),     64'(m_done));
        check({tag, ".overflow"}, 64'(overflow_o), 64'(m_ovf));
        check({tag, ".payload"},  64'(payload_o),  64'(m_payload()));
        check({tag, ".checksum"}, 64'(checksum_o), 64'(m_checksum()));
    endtask

    // Called at posedge+1: drive, clock, update model, check.
    task automatic cycle(input string tag, input bit s, input bit v, input logic [IW-1:0] d);
        start_i = s; valid_i = v; res_i = d;
        @(posedge clk_i);
        model_edge(s, v, d);
        #1;
        start_i = 0; valid_i = 0; res_i = '0;
        $display("txn %s start=%0b valid=%0b data=0x%02h count=%0d done=%0b ovf=%0b payload=0x%08h cks=0x%04h",
                 tag, s, v, d, count_o, done_o, overflow_o, payload_o, checksum_o);
        check_all(tag);
    endtask

    task automatic run4(input string tag, input logic [IW-1:0] a, input logic [IW-1:0] b,
                        input logic [IW-1:0] c, input logic [IW-1:0] e, input int gap);
        logic [IW-1:0] beats [4];
        beats[0] = a; beats[1] = b; beats[2] = c; beats[3] = e;
        cycle({tag, ".start"}, 1, 0, '0);
        for (int i = 0; i < 4; i++) begin
            cycle({tag, ".beat"}, 0, 1, beats[i]);
            for (int g = 0; g < gap; g++) cycle({tag, ".gap"}, 0, 0, '0);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        start_i = 0; valid_i = 0; res_i = '0;
        reset_ni = 0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk_i);
        reset_ni = 1;
        @(posedge clk_i);
        #1;
        check_all("post_reset");

        // 1: back-to-back
        run4("t1", 8'h11, 8'h22, 8'h33, 8'h44, 0);
        check("t1.payload_const", 64'(payload_o), 64'h44332211);
        check("t1.done_const", 64'(done_o), 64'd1);

        // 2: gaps of two idle cycles
        run4("t2", 8'h11, 8'h22, 8'h33, 8'h44, 2);
        check("t2.payload_const", 64'(payload_o), 64'h44332211);

        // 3: overflow in DONE, then restart
        cycle("t3.ovf", 0, 1, 8'h55);
        cycle("t3.hold", 0, 0, '0);
        check("t3.ovf_const", 64'(overflow_o), 64'd1);
        cycle("t3.restart", 1, 0, '0);

        // 4: start with valid after two beats
        cycle("t4.b0", 0, 1, 8'h01);
        cycle("t4.b1", 0, 1, 8'h02);
        cycle("t4.start_valid", 1, 1, 8'h99);
        cycle("t4.aa", 0, 1, 8'hAA);
        check("t4.slot0", 64'(payload_o[7:0]), 64'hAA);

        // 5: async reset mid-run after three beats
        cycle("t5.start", 1, 0, '0);
        cycle("t5.b0", 0, 1, 8'h10);
        cycle("t5.b1", 0, 1, 8'h20);
        cycle("t5.b2", 0, 1, 8'h30);
        #2;
        reset_ni = 0;
        #1;
        model_reset();
        check_all("t5.async");
        @(negedge clk_i);
        reset_ni = 1;
        @(posedge clk_i);
        #1;
        cycle("t5.idle_beat", 0, 1, 8'h77);

        // 6: checksum of four 0xFF
        run4("t6", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
`ifdef RES_COLLECTOR_CHECKSUM_EN
        check("t6.cks_const", 64'(checksum_o), 64'h03FC);
`else
        check("t6.cks_const", 64'(checksum_o), 64'h0);
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bit s, v;
            s = ($urandom_range(0, 11) == 0);
            v = ($urandom_range(0, 1) == 1);
            cycle("rand", s, v, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
